uart_tx_frame: RTL

- Parametrised UART transmitter and the successor to the fixed 8N1 serializer.
- Configurable data width, parity mode and stop-bit count.
- Valid/ready input handshake with a one-entry holding register, so frames go out back-to-back with no idle bit between them.
- Sits between a byte source (FIFO/CPU bridge) and the pad. Bit timing comes from an external baud tick `clk_en`.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_hold.sv | 51 +++++
 rtl/uart_tx_frame.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the parametrised UART transmitter: FSM states,
// line levels and parity mode selectors.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register in front of the serializer; parity is folded
// in at accept time so the FSM never looks at the raw byte twice.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 full_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_o
);

    localparam logic PAR_INV = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;

    // accept wins over load so a refill on the load cycle keeps the entry full
    always_comb begin
        full_d = full_q;
        if (accept_i)    full_d = 1'b1;
        else if (load_i) full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_i) begin
            data_q <= data_i;
            par_q  <= (^data_i) ^ PAR_INV;
        end
    end

    assign full_o   = full_q;
    assign data_o   = data_q;
    assign parity_o = par_q;

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// STOP_BITS stop bits, back-to-back frames via a one-entry holding register.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int             CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [CW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 tx_q;
    logic                 done_q;

    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_par;
    logic                 accept;
    logic                 frame_end;
    logic                 load;

    assign accept    = tx_valid && !hold_full;
    assign frame_end = (state_q == S_STOP) && (stop_cnt_q == LAST_STOP);
    // Must match the FSM's own load conditions exactly.
    assign load      = clk_en && hold_full && ((state_q == S_IDLE) || frame_end);

    uart_tx_hold #(
        .DATA_BITS (DATA_BITS),
        .PARITY_ODD(PARITY_ODD != 0)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept_i(accept),
        .load_i  (load),
        .data_i  (tx_data),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .parity_o(hold_par)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= LINE_IDLE;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clk_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (hold_full) begin
                            shift_q <= hold_data;
                            par_q   <= hold_par;
                            tx_q    <= LINE_START;
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_cnt_q != LAST_BIT) begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (PARITY_EN != 0) begin
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
                        end else begin
                            tx_q       <= LINE_STOP;
                            stop_cnt_q <= 1'b0;
                            state_q    <= S_STOP;
                        end
                    end
                    S_PARITY: begin
                        tx_q       <= LINE_STOP;
                        stop_cnt_q <= 1'b0;
                        state_q    <= S_STOP;
                    end
                    S_STOP: begin
                        if (stop_cnt_q != LAST_STOP) begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            if (hold_full) begin
                                shift_q <= hold_data;
                                par_q   <= hold_par;
                                tx_q    <= LINE_START;
                                state_q <= S_START;
                            end else begin
                                tx_q    <= LINE_IDLE;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        tx_q    <= LINE_IDLE;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready = !hold_full;
    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_done  = done_q;

endmodule
